// File: rtl/branch_predictor_btb_pkg.sv
// branch_predictor_btb_pkg: shared constants, counter encoding and BTB entry layout for the branch predictor.
package branch_predictor_btb_pkg;
  localparam int RV_XLEN = 32;
  localparam int BTB_DEFAULT_ENTRIES = 16;
  localparam int BTB_DEFAULT_TAG_BITS = 8;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_e;
  typedef struct packed {
    logic                            valid;
    logic [BTB_DEFAULT_TAG_BITS-1:0] tag;
    logic [RV_XLEN-1:0]              target;
    logic                            is_jump;
    bp_ctr_e                         ctr;
  } btb_entry_t;
endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating up/down counter (ctr_i current, up_i direction, ctr_o next).
module sat_counter2
  import branch_predictor_btb_pkg::*;
(
  input  bp_ctr_e ctr_i,
  input  logic    up_i,
  output bp_ctr_e ctr_o
);
  always_comb
    ctr_o = up_i ? (ctr_i == STRONG_T  ? STRONG_T  : bp_ctr_e'(ctr_i + 2'd1))
                 : (ctr_i == STRONG_NT ? STRONG_NT : bp_ctr_e'(ctr_i - 2'd1));
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit direction counters; fetch_pc -> pred_taken/pred_target, ex_* resolution -> mispredict/redirect_pc, table update next edge, stat_* counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int XLEN        = RV_XLEN,
  parameter int BTB_ENTRIES = BTB_DEFAULT_ENTRIES,
  parameter int TAG_BITS    = BTB_DEFAULT_TAG_BITS,
  parameter int STAT_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_tables,
  input  logic [XLEN-1:0]      fetch_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jump,
  input  logic                 ex_taken,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  logic [BTB_ENTRIES-1:0] valid_q, valid_d, jmp_q, jmp_d;
  logic [TAG_BITS-1:0]    tag_q [BTB_ENTRIES];
  logic [TAG_BITS-1:0]    tag_d [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];
  bp_ctr_e                ctr_q [BTB_ENTRIES];
  bp_ctr_e                ctr_d [BTB_ENTRIES];
  bp_ctr_e                ctr_nxt [BTB_ENTRIES];
  logic [STAT_BITS-1:0]   br_q, br_d, mis_q, mis_d;
  logic [IDX-1:0]         f_idx, e_idx;
  logic [TAG_BITS-1:0]    f_tag, e_tag;
  logic                   f_hit, e_hit, res, unused_pc;
  assign f_idx = fetch_pc[IDX+1:2];
  assign f_tag = fetch_pc[TAG_BITS+IDX+1:IDX+2];
  assign e_idx = ex_pc[IDX+1:2];
  assign e_tag = ex_pc[TAG_BITS+IDX+1:IDX+2];
  assign unused_pc = ^{fetch_pc, ex_pc};
  assign f_hit = valid_q[f_idx] && tag_q[f_idx] == f_tag;
  assign e_hit = valid_q[e_idx] && tag_q[e_idx] == e_tag;
  assign pred_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
  assign pred_target = pred_taken ? target_q[f_idx] : '0;
  // A branch+jump encoding still counts as a resolve; is_jump wins wherever they differ.
  assign res = ex_valid && (ex_is_branch || ex_is_jump);
  assign mispredict = !rst && res &&
                      ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
  assign redirect_pc = mispredict ? (ex_taken ? ex_target : ex_pc + XLEN'(4)) : '0;
  for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_ctr
    sat_counter2 u_ctr (.ctr_i(ctr_q[g]), .up_i(ex_taken), .ctr_o(ctr_nxt[g]));
  end
  always_comb begin
    valid_d  = flush_tables ? '0 : valid_q;
    jmp_d    = jmp_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    // Flush wins over a coincident update; fetch reads pre-update contents (no bypass).
    if (res && !flush_tables) begin
      if (ex_taken) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = ex_target;
        jmp_d[e_idx]    = ex_is_jump;
        ctr_d[e_idx]    = ex_is_jump ? STRONG_T : (e_hit ? ctr_nxt[e_idx] : WEAK_T);
      end else if (e_hit)
        ctr_d[e_idx] = ctr_nxt[e_idx];
    end
    br_d  = (res && br_q != '1) ? br_q + STAT_BITS'(1) : br_q;
    mis_d = (mispredict && mis_q != '1) ? mis_q + STAT_BITS'(1) : mis_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= WEAK_NT;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  // Payload is meaningless while its valid bit is clear, so it needs no reset.
  always_ff @(posedge clk) begin
    jmp_q    <= jmp_d;
    tag_q    <= tag_d;
    target_q <= target_d;
  end
  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed and randomized checks of branch_predictor_btb against a behavioural BTB model.
module tb_branch_predictor_btb;
  logic        clk = 0, rst = 1, flush_tables = 0;
  logic [31:0] fetch_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic        ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_taken = 0, ex_pred_taken = 0;
  logic        pred_taken, mispredict, pred_taken_s, mispredict_s;
  logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts, pred_target_s, redirect_pc_s;
  logic [3:0]  stat_branches_s, stat_mispredicts_s;
  int          n_cmp = 0, n_bad = 0;
  bit          mvalid [16];
  bit          mjmp [16];
  int          mtag [16];
  int          mctr [16];
  logic [31:0] mtgt [16];
  longint      m_br, m_mis;
  always #5 clk = ~clk;
  branch_predictor_btb dut (
    .clk(clk), .rst(rst), .flush_tables(flush_tables), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));
  branch_predictor_btb #(.STAT_BITS(4)) dut_s (
    .clk(clk), .rst(rst), .flush_tables(flush_tables), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken_s), .pred_target(pred_target_s), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .mispredict(mispredict_s),
    .redirect_pc(redirect_pc_s), .stat_branches(stat_branches_s), .stat_mispredicts(stat_mispredicts_s));
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction
  function automatic int mtagf(input logic [31:0] pc);
    return int'((pc >> 6) % 256);
  endfunction
  function automatic bit mhit(input logic [31:0] pc);
    return mvalid[midx(pc)] && mtag[midx(pc)] == mtagf(pc);
  endfunction
  function automatic bit mpred(input logic [31:0] pc);
    return mhit(pc) && (mjmp[midx(pc)] || mctr[midx(pc)] >= 2);
  endfunction
  function automatic logic [31:0] mptgt(input logic [31:0] pc);
    return mpred(pc) ? mtgt[midx(pc)] : 32'h0;
  endfunction
  function automatic bit mres();
    return ex_valid && (ex_is_branch || ex_is_jump);
  endfunction
  function automatic bit mmis();
    return mres() && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 0;
      mctr[i] = 1;
    end
    m_br = 0;
    m_mis = 0;
  endtask
  always @(posedge clk) if (!rst) begin
    int i;
    bit h;
    i = midx(ex_pc);
    h = mhit(ex_pc);
    if (mres()) m_br++;
    if (mmis()) m_mis++;
    if (flush_tables) begin
      for (int k = 0; k < 16; k++) mvalid[k] = 0;
    end else if (mres()) begin
      if (ex_taken) begin
        mvalid[i] = 1;
        mtag[i] = mtagf(ex_pc);
        mtgt[i] = ex_target;
        mjmp[i] = ex_is_jump;
        mctr[i] = ex_is_jump ? 3 : h ? (mctr[i] < 3 ? mctr[i] + 1 : 3) : 2;
      end else if (h)
        mctr[i] = mctr[i] > 0 ? mctr[i] - 1 : 0;
    end
  end
  always @(negedge clk) begin
    bit em;
    em = !rst && mmis();
    cmp("pred_taken", 32'(pred_taken), 32'(mpred(fetch_pc)));
    cmp("pred_target", pred_target, mptgt(fetch_pc));
    cmp("mispredict", 32'(mispredict), 32'(em));
    cmp("redirect_pc", redirect_pc, em ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'h0);
    cmp("stat_branches", stat_branches, 32'(m_br));
    cmp("stat_mispredicts", stat_mispredicts, 32'(m_mis));
    cmp("stat_branches_sat4", 32'(stat_branches_s), 32'(m_br > 15 ? 15 : m_br));
    cmp("stat_mispredicts_sat4", 32'(stat_mispredicts_s), 32'(m_mis > 15 ? 15 : m_mis));
  end
  task automatic step(input logic [31:0] fpc, input logic ev, input logic br, input logic j,
                      input logic tk, input logic [31:0] epc, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt, input logic fl);
    @(posedge clk);
    #1;
    fetch_pc = fpc; ex_valid = ev; ex_is_branch = br; ex_is_jump = j; ex_taken = tk;
    ex_pc = epc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt; flush_tables = fl;
    #1;
  endtask
  task automatic idle(input logic [31:0] fpc);
    step(fpc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rst_on();
    @(posedge clk);
    #3;
    rst = 1;
    model_reset();
  endtask
  task automatic rst_off();
    #4;
    rst = 0;
  endtask
  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) p = p | ($urandom & 32'hFFFFC000);
    return p;
  endfunction
  initial begin
    logic [31:0] epc, tgt;
    int kind;
    model_reset();
    #12 rst = 0;
    idle(32'h100);
    cmp("cold_pred_taken", 32'(pred_taken), 32'h0);
    cmp("cold_pred_target", pred_target, 32'h0);
    step(32'h100, 1, 1, 0, 1, 32'h100, 32'h140, 0, 0, 0);
    cmp("cold_mispredict", 32'(mispredict), 32'h1);
    cmp("cold_redirect", redirect_pc, 32'h140);
    idle(32'h100);
    cmp("alloc_pred_taken", 32'(pred_taken), 32'h1);
    cmp("alloc_pred_target", pred_target, 32'h140);
    step(32'h100, 1, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140, 0);
    cmp("hyst_mispredict", 32'(mispredict), 32'h1);
    cmp("hyst_redirect", redirect_pc, 32'h104);
    idle(32'h100);
    cmp("hyst_weak_nt_pred", 32'(pred_taken), 32'h0);
    step(32'h100, 1, 1, 0, 1, 32'h100, 32'h140, 0, 0, 0);
    step(32'h100, 1, 1, 0, 1, 32'h100, 32'h140, 1, 32'h140, 0);
    cmp("hyst_correct_no_mispredict", 32'(mispredict), 32'h0);
    step(32'h100, 1, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140, 0);
    step(32'h100, 1, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140, 0);
    cmp("hyst_weak_t_pred", 32'(pred_taken), 32'h1);
    step(32'h100, 1, 1, 0, 0, 32'h100, 32'h140, 0, 0, 0);
    step(32'h100, 1, 1, 0, 0, 32'h100, 32'h140, 0, 0, 0);
    step(32'h100, 1, 1, 0, 1, 32'h100, 32'h140, 0, 0, 0);
    idle(32'h100);
    cmp("hyst_hit_from_00_pred", 32'(pred_taken), 32'h0);
    step(32'h0, 1, 0, 1, 1, 32'h200, 32'h3000, 0, 0, 0);
    step(32'h0, 1, 0, 1, 1, 32'h200, 32'h3010, 1, 32'h3000, 0);
    cmp("jump_tgt_mispredict", 32'(mispredict), 32'h1);
    cmp("jump_tgt_redirect", redirect_pc, 32'h3010);
    idle(32'h200);
    cmp("jump_pred_taken", 32'(pred_taken), 32'h1);
    cmp("jump_pred_target", pred_target, 32'h3010);
    step(32'h0, 1, 1, 0, 1, 32'h100, 32'h140, 0, 0, 0);
    step(32'h0, 1, 1, 0, 1, 32'h140, 32'h500, 0, 0, 0);
    idle(32'h100);
    cmp("alias_old_miss", 32'(pred_taken), 32'h0);
    step(32'h140, 1, 1, 0, 0, 32'h180, 32'h600, 0, 0, 0);
    cmp("alias_new_hit", 32'(pred_taken), 32'h1);
    cmp("alias_new_target", pred_target, 32'h500);
    idle(32'h180);
    cmp("alias_nt_no_alloc", 32'(pred_taken), 32'h0);
    idle(32'h140);
    cmp("alias_entry_kept", 32'(pred_taken), 32'h1);
    rst_on();
    #1;
    cmp("async_rst_pred", 32'(pred_taken), 32'h0);
    cmp("async_rst_branches", stat_branches, 32'h0);
    cmp("async_rst_mispredicts", stat_mispredicts, 32'h0);
    rst_off();
    step(32'h0, 1, 1, 0, 1, 32'h100, 32'h140, 0, 0, 0);
    step(32'h0, 1, 0, 1, 1, 32'h244, 32'h900, 0, 0, 1);
    idle(32'h100);
    cmp("flush_miss_100", 32'(pred_taken), 32'h0);
    cmp("flush_stat_counts", stat_branches, 32'h2);
    idle(32'h244);
    cmp("flush_drops_update", 32'(pred_taken), 32'h0);
    rst_on();
    rst_off();
    for (int i = 0; i < 10; i++) step(32'h0, 1, 1, 0, i < 3, 32'h400, 32'h480, 0, 0, 0);
    idle(32'h0);
    cmp("stats_branches_10", stat_branches, 32'd10);
    cmp("stats_mispredicts_3", stat_mispredicts, 32'd3);
    for (int i = 0; i < 10; i++) step(32'h0, 1, 1, 0, 1, 32'h400, 32'h480, 0, 0, 0);
    idle(32'h0);
    cmp("sat4_branches_hold", 32'(stat_branches_s), 32'd15);
    cmp("sat4_mispredicts_13", 32'(stat_mispredicts_s), 32'd13);
    for (int i = 0; i < 5; i++) step(32'h0, 1, 1, 0, 1, 32'h400, 32'h480, 0, 0, 0);
    idle(32'h0);
    cmp("sat4_mispredicts_hold", 32'(stat_mispredicts_s), 32'd15);
    cmp("wide_branches_25", stat_branches, 32'd25);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_on();
        rst_off();
      end
      kind = int'($urandom_range(0, 9));
      epc = rpc();
      case ($urandom_range(0, 3))
        0: tgt = 32'h140;
        1: tgt = 32'h500;
        2: tgt = 32'h3000;
        default: tgt = $urandom & 32'hFFFFFFFC;
      endcase
      if ($urandom_range(0, 3) != 0)
        step(rpc(), $urandom_range(0, 9) < 8, kind < 6 || kind == 8, kind == 6 || kind == 7 || kind == 8,
             (kind >= 6 && kind <= 8) ? 1'b1 : 1'($urandom_range(0, 1)), epc, tgt,
             mpred(epc), mptgt(epc), $urandom_range(0, 24) == 0);
      else
        step(rpc(), $urandom_range(0, 9) < 8, kind < 6 || kind == 8, kind == 6 || kind == 7 || kind == 8,
             (kind >= 6 && kind <= 8) ? 1'b1 : 1'($urandom_range(0, 1)), epc, tgt,
             1'($urandom_range(0, 1)), tgt, $urandom_range(0, 24) == 0);
    end
    idle(32'h0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch presents a PC and gets a taken/target prediction in the same cycle.
- Execute returns the resolved branch/jump outcome. The block flags a mispredict, supplies the redirect PC, and updates its tables on the next edge.
- Sits between fetch (PC select) and the execute-stage branch resolution logic. Also keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, datapath/PC width (from riscv_pkg).
- BTB_ENTRIES, 16, number of entries; power of two, minimum 2.
- TAG_BITS, 8, stored tag width; TAG_BITS + log2(BTB_ENTRIES) + 2 <= XLEN.
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_tables  in  1  synchronous clear of all BTB valid bits.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  prediction: redirect fetch.
- pred_target  out  XLEN  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  execute-stage instruction valid.
- ex_pc  in  XLEN  PC of the resolving instruction.
- ex_is_branch  in  1  conditional branch.
- ex_is_jump  in  1  JAL/JALR.
- ex_taken  in  1  resolved direction.
- ex_target  in  XLEN  resolved target (already LSB-cleared for JALR).
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- mispredict  out  1  combinational; flush younger instructions.
- redirect_pc  out  XLEN  correct next PC when mispredict=1, else 0.
- stat_branches  out  STAT_BITS  resolved branches + jumps.
- stat_mispredicts  out  STAT_BITS  mispredicts.

Behaviour:
- **Reset (async, rst=1):** all valid bits are 0, all counters are 01 (weakly not-taken), statistics are 0, and table contents beyond valid/counter are don't-care.
  - Outputs during reset: pred_taken=0, pred_target=0.
  - mispredict and redirect_pc are driven from inputs and are gated low/0 while rst=1.
- **Indexing:**
  - idx = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - tag = pc[TAG_BITS+IDX+1:IDX+2].
  - pc[1:0] is ignored.
- **Entry contents:** valid, tag, target[XLEN-1:0], is_jump, ctr[1:0].
- **Prediction (combinational, 0 latency):**
  - hit = valid[idx] && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : 0.
- **Resolution (combinational):** let res = ex_valid && (ex_is_branch || ex_is_jump).
  - mispredict = res && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4, modulo 2^XLEN.
  - ex_is_branch && ex_is_jump together is illegal; treat it as a jump.
- **Update (next rising edge when res=1):**
  - Taken (branch or jump): write valid=1, tag, target=ex_target, is_jump=ex_is_jump.
  - Jump: ctr := 11.
  - Branch, entry was hit: ctr saturating ++ on taken, -- on not-taken.
  - Branch, newly allocated (miss or tag replaced): ctr := 10 on taken.
  - Not-taken branch that misses: no allocation, no write.
  - Not-taken branch that hits: decrement ctr only; saturate at 00, entry stays valid.
- **Statistics:**
  - stat_branches += 1 when res=1.
  - stat_mispredicts += 1 when mispredict=1.
  - Both saturate at all-ones; no wrap.
- **Same-cycle read/write of one index:** fetch sees pre-update contents; no bypass.
- **flush_tables:**
  - Clears all valid bits at the edge; counters and statistics are untouched.
  - If it coincides with an update, flush wins and the update is dropped.
  - Statistics still count that cycle.
- **Reset mid-update:** the async reset dominates; no partial write is retained.

Decomposition:
- riscv_pkg additions:
  - btb_entry_t struct (valid, tag, target, is_jump, ctr).
  - bp_ctr_e enum: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - Constants BTB_DEFAULT_ENTRIES and BTB_DEFAULT_TAG_BITS.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down counter with next-state function. It is reused for every entry.
- The table is a register array inside branch_predictor_btb; no SRAM macro.

Test Plan:
- **Cold miss:** after reset, fetch_pc=0x100 -> pred_taken=0, pred_target=0.
  - Resolve BEQ at 0x100 taken to 0x140 with ex_pred_taken=0 -> mispredict=1, redirect_pc=0x140.
  - Next cycle, fetch 0x100 -> pred_taken=1, pred_target=0x140.
- **Counter hysteresis:** with a branch at 0x100 allocated (ctr=10), resolve not-taken with pred_taken=1 -> mispredict=1, redirect_pc=0x104.
  - ctr becomes 01, so the next fetch predicts 0.
  - Two takens -> ctr 10 then 11; three not-takens from 11 -> 10, 01, 00, then saturates.
- **Jump and target mismatch:** JALR at 0x200 to 0x3000 is allocated.
  - A later resolve to 0x3010 with ex_pred_taken=1, ex_pred_target=0x3000 -> mispredict=1, redirect_pc=0x3010; entry target becomes 0x3010.
- **Aliasing, BTB_ENTRIES=16:** 0x100 and 0x140 share idx 0 with tags 0x04/0x05.
  - Allocate 0x100, then a taken 0x140 replaces it -> fetch 0x100 misses, 0x140 hits.
  - A not-taken 0x180 miss does not allocate.
- **Flush:** asserting flush_tables coincident with a taken update at 0x100 -> next cycle every fetch misses.
  - stat_branches still increments by 1.
- **Statistics and reset:**
  - 10 resolves, 3 mispredicts -> stat_branches=10, stat_mispredicts=3.
  - Preset near saturation with STAT_BITS=4 -> holds at 15.
  - Async rst pulse mid-test between edges -> counters immediately 0 and all fetches miss.
